// File: rtl/branch_ctrl_pkg.sv
// Shared types and constants for the branch/halt redirect controller.
package branch_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SQUASH = 2'd1,
    HALTED = 2'd2
  } redirect_state_e;

  localparam int PC_STEP         = 4;
  localparam int FLUSH_DEPTH_DEF = 2;

endpackage

// File: rtl/sat_counter32.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter32 (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  output logic [31:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != 32'hFFFF_FFFF)) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// PC redirect / squash / halt sequencer for the pipeline front end.
// Optional statistics counters are built when BRANCH_CTRL_STATS_EN is defined.
//
// state  | meaning
// RUN    | normal fetch; accepts Halt, PcSel and Stall
// SQUASH | wrong-path instructions still in flight; ID/EX squashed
// HALTED | core parked at HoldPC until Resume
module pc_redirect_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int PC_W        = 9,
  parameter int FLUSH_DEPTH = FLUSH_DEPTH_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] CurPC,
  input  logic            PcSel,
  input  logic [31:0]     BrPC,
  input  logic            Halt,
  input  logic            Resume,
  input  logic            Stall,
  output logic            PcWrite,
  output logic [PC_W-1:0] PcNext,
  output logic            FlushIF,
  output logic            FlushID,
  output logic            Halted,
  output logic            RangeErr,
  output logic [31:0]     TakenCount,
  output logic [31:0]     FlushCycles
);

  localparam int CNT_W = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_DEPTH - 1);
  localparam logic [PC_W-1:0]  STEP     = PC_W'(PC_STEP);

  redirect_state_e state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [PC_W-1:0]  hold_pc, hold_nxt;
  logic             range_set;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      cnt      <= '0;
      hold_pc  <= '0;
      RangeErr <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      hold_pc  <= hold_nxt;
      RangeErr <= RangeErr | range_set;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hold_nxt  = hold_pc;
    range_set = 1'b0;
    PcWrite   = 1'b0;
    PcNext    = CurPC + STEP;
    FlushIF   = 1'b0;
    FlushID   = 1'b0;
    Halted    = 1'b0;
    if (reset) begin
      FlushIF = 1'b1;
      FlushID = 1'b1;
    end else begin
      unique case (state)
        RUN: begin
          if (Halt) begin
            FlushIF   = 1'b1;
            FlushID   = 1'b1;
            hold_nxt  = CurPC;
            state_nxt = HALTED;
          end else if (PcSel) begin
            // Redirect beats a simultaneous load-use stall.
            PcWrite   = 1'b1;
            PcNext    = BrPC[PC_W-1:0];
            FlushIF   = 1'b1;
            FlushID   = 1'b1;
            range_set = ((BrPC >> PC_W) != 32'd0);
            if (FLUSH_DEPTH > 1) begin
              cnt_nxt   = CNT_LOAD;
              state_nxt = SQUASH;
            end
          end else begin
            PcWrite = !Stall;
          end
        end
        SQUASH: begin
          FlushID = 1'b1;
          PcWrite = !Stall;
          if (!Stall) begin
            if (cnt <= CNT_W'(1)) begin
              state_nxt = RUN;
            end else begin
              cnt_nxt = cnt - 1'b1;
            end
          end
        end
        HALTED: begin
          Halted  = 1'b1;
          FlushIF = 1'b1;
          FlushID = 1'b1;
          PcNext  = hold_pc + STEP;
          if (Resume) begin
            PcWrite   = 1'b1;
            state_nxt = RUN;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

`ifdef BRANCH_CTRL_STATS_EN
  logic taken_inc, flush_inc;

  assign taken_inc = !reset && (state == RUN) && !Halt && PcSel;
  assign flush_inc = !reset && FlushID && !Halted;

  sat_counter32 u_taken_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (taken_inc),
    .count (TakenCount)
  );

  sat_counter32 u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .count (FlushCycles)
  );
`else
  assign TakenCount  = '0;
  assign FlushCycles = '0;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl with a cycle-level reference model.
module tb_pc_redirect_ctrl;

  localparam int PC_W   = 9;
  localparam int FD     = 2;
  localparam int PC_MOD = 1 << PC_W;

  logic            clk = 1'b0;
  logic            reset;
  logic [PC_W-1:0] CurPC;
  logic            PcSel;
  logic [31:0]     BrPC;
  logic            Halt, Resume, Stall;
  logic            PcWrite;
  logic [PC_W-1:0] PcNext;
  logic            FlushIF, FlushID, Halted, RangeErr;
  logic [31:0]     TakenCount, FlushCycles;

  int checks   = 0;
  int failures = 0;

  // Reference model: halted flag, squash cycles still owed, parked PC, flags, stats.
  bit          m_halted;
  int          m_squash_left;
  int          m_hold;
  bit          m_rerr;
  int unsigned m_taken, m_flush;

  pc_redirect_ctrl #(.PC_W(PC_W), .FLUSH_DEPTH(FD)) dut (
    .clk         (clk),
    .reset       (reset),
    .CurPC       (CurPC),
    .PcSel       (PcSel),
    .BrPC        (BrPC),
    .Halt        (Halt),
    .Resume      (Resume),
    .Stall       (Stall),
    .PcWrite     (PcWrite),
    .PcNext      (PcNext),
    .FlushIF     (FlushIF),
    .FlushID     (FlushID),
    .Halted      (Halted),
    .RangeErr    (RangeErr),
    .TakenCount  (TakenCount),
    .FlushCycles (FlushCycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    bit e_pcw, e_fif, e_fid, e_hal;
    int e_pcn;
    int unsigned e_tc, e_fc;
    if (reset) begin
      m_halted = 0; m_squash_left = 0; m_hold = 0; m_rerr = 0; m_taken = 0; m_flush = 0;
      chk("rst_pcwrite", {31'd0, PcWrite}, 32'd0);
      chk("rst_flushif", {31'd0, FlushIF}, 32'd1);
      chk("rst_flushid", {31'd0, FlushID}, 32'd1);
      chk("rst_halted", {31'd0, Halted}, 32'd0);
      chk("rst_rangeerr", {31'd0, RangeErr}, 32'd0);
      chk("rst_taken", TakenCount, 32'd0);
      chk("rst_flushcyc", FlushCycles, 32'd0);
      return;
    end
`ifdef BRANCH_CTRL_STATS_EN
    e_tc = m_taken;
    e_fc = m_flush;
`else
    e_tc = 0;
    e_fc = 0;
`endif
    chk("rangeerr", {31'd0, RangeErr}, {31'd0, m_rerr});
    chk("taken_count", TakenCount, e_tc);
    chk("flush_cycles", FlushCycles, e_fc);
    e_pcn = (int'(CurPC) + 4) % PC_MOD;
    e_pcw = 0; e_fif = 0; e_fid = 0; e_hal = 0;
    if (m_halted) begin
      e_hal = 1; e_fif = 1; e_fid = 1;
      e_pcw = Resume;
      e_pcn = (m_hold + 4) % PC_MOD;
      if (Resume) m_halted = 0;
    end else if (m_squash_left > 0) begin
      e_fid = 1;
      e_pcw = !Stall;
      if (!Stall) m_squash_left--;
    end else if (Halt) begin
      e_fif = 1; e_fid = 1;
      m_hold = int'(CurPC);
      m_halted = 1;
    end else if (PcSel) begin
      e_pcw = 1; e_fif = 1; e_fid = 1;
      e_pcn = int'(BrPC % PC_MOD);
      if (BrPC >= PC_MOD) m_rerr = 1;
      m_squash_left = FD - 1;
      m_taken++;
    end else begin
      e_pcw = !Stall;
    end
    if (e_fid && !e_hal) m_flush++;
    chk("pcwrite", {31'd0, PcWrite}, {31'd0, e_pcw});
    chk("flushif", {31'd0, FlushIF}, {31'd0, e_fif});
    chk("flushid", {31'd0, FlushID}, {31'd0, e_fid});
    chk("halted", {31'd0, Halted}, {31'd0, e_hal});
    if (e_pcw) chk("pcnext", {{(32-PC_W){1'b0}}, PcNext}, e_pcn);
  endtask

  // Drive one cycle of inputs just after the rising edge, then check at the falling edge.
  task automatic tick(input bit r, input int cur, input bit sel, input int br,
                      input bit h, input bit res, input bit st);
    @(posedge clk);
    #1;
    reset  = r;
    CurPC  = cur[PC_W-1:0];
    PcSel  = sel;
    BrPC   = br;
    Halt   = h;
    Resume = res;
    Stall  = st;
    @(negedge clk);
    model_check();
  endtask

  task automatic idle(input int cur);
    tick(0, cur, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1; CurPC = '0; PcSel = 0; BrPC = '0; Halt = 0; Resume = 0; Stall = 0;
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0, 0);
    chk("lit_rst_pcwrite", {31'd0, PcWrite}, 32'd0);
    chk("lit_rst_flushid", {31'd0, FlushID}, 32'd1);

    idle('h010);
    chk("lit_seq_pcnext", {23'd0, PcNext}, 32'h014);

    // Redirect, then a squash cycle whose PcSel must be ignored.
    tick(0, 'h014, 1, 'h40, 0, 0, 0);
    chk("lit_redir_pcnext", {23'd0, PcNext}, 32'h040);
    chk("lit_redir_flushif", {31'd0, FlushIF}, 32'd1);
    tick(0, 'h040, 1, 'h80, 0, 0, 0);
    chk("lit_sq_flushif", {31'd0, FlushIF}, 32'd0);
    chk("lit_sq_pcnext", {23'd0, PcNext}, 32'h044);
    idle('h044);
    chk("lit_run_flushid", {31'd0, FlushID}, 32'd0);

    // Stall held inside the squash window.
    tick(0, 'h048, 1, 'h100, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick(0, 'h100, 0, 0, 0, 0, 1);
    chk("lit_sqstall_pcwrite", {31'd0, PcWrite}, 32'd0);
    chk("lit_sqstall_flushid", {31'd0, FlushID}, 32'd1);
    idle('h100);
    chk("lit_sqexit_flushid", {31'd0, FlushID}, 32'd1);
    idle('h104);
    chk("lit_after_sq_flushid", {31'd0, FlushID}, 32'd0);

    // Halt, ignored requests while parked, then resume.
    tick(0, 'h1F0, 0, 0, 1, 0, 0);
    tick(0, 'h1F4, 1, 'h20, 1, 0, 1);
    chk("lit_halted", {31'd0, Halted}, 32'd1);
    for (int i = 0; i < 4; i++) idle('h1F4);
    tick(0, 'h1F4, 0, 0, 0, 1, 0);
    chk("lit_resume_pcnext", {23'd0, PcNext}, 32'h1F4);
    chk("lit_resume_pcwrite", {31'd0, PcWrite}, 32'd1);
    idle('h1F4);
    chk("lit_unhalted", {31'd0, Halted}, 32'd0);
    tick(0, 'h1F8, 0, 0, 0, 1, 0);

    // Out-of-range target, sticky error, PC wrap.
    tick(0, 'h000, 1, 'h204, 0, 0, 0);
    chk("lit_range_pcnext", {23'd0, PcNext}, 32'h004);
    idle('h004);
    idle('h1FC);
    chk("lit_wrap_pcnext", {23'd0, PcNext}, 32'h000);
    chk("lit_rangeerr_sticky", {31'd0, RangeErr}, 32'd1);

    // Redirect together with stall.
    tick(0, 'h010, 1, 'h30, 0, 0, 1);
    chk("lit_selstall_pcwrite", {31'd0, PcWrite}, 32'd1);
    idle('h030);

    // Reset while halted.
    tick(0, 'h050, 0, 0, 1, 0, 0);
    idle('h054);
    tick(1, 'h054, 0, 0, 0, 0, 0);
    chk("lit_rst_halted", {31'd0, Halted}, 32'd0);
    idle('h020);
    chk("lit_post_rst_pcnext", {23'd0, PcNext}, 32'h024);

    // Three redirects for the statistics counters.
    for (int i = 0; i < 3; i++) begin
      tick(0, 'h024, 1, 'h40, 0, 0, 0);
      idle('h040);
    end
    idle('h044);
`ifdef BRANCH_CTRL_STATS_EN
    chk("lit_taken3", TakenCount, 32'd3);
    chk("lit_flush6", FlushCycles, 32'd6);
`else
    chk("lit_taken_off", TakenCount, 32'd0);
    chk("lit_flush_off", FlushCycles, 32'd0);
`endif

    tick(0, 'h048, 0, 0, 1, 0, 0);
    tick(0, 'h04C, 0, 0, 0, 1, 0);
    idle('h04C);
    idle('h050);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_redirect_ctrl.md
# pc_redirect_ctrl

Sequencing controller for the branch/halt redirect path of the RISC-V pipeline. It consumes the branch unit's select, target and halt indications, drives the PC register's write enable and next value, and squashes wrong-path instructions for a configurable number of cycles. It also parks the core in a halted state until an external resume.

## Interface
Parameters:
- PC_W, 9, width of the PC register.
- FLUSH_DEPTH, 2, number of cycles (≥1) during which wrong-path instructions are squashed after a taken redirect.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- CurPC  in  PC_W  current PC register value.
- PcSel  in  1  redirect request from the branch unit.
- BrPC  in  32  redirect target from the branch unit.
- Halt  in  1  halt instruction resolved in EX.
- Resume  in  1  single-cycle pulse that releases the halted state.
- Stall  in  1  load-use stall from the hazard unit.
- PcWrite  out  1  PC register write enable.
- PcNext  out  PC_W  next PC value.
- FlushIF  out  1  squash the IF/ID register.
- FlushID  out  1  squash the ID/EX register.
- Halted  out  1  core is parked.
- RangeErr  out  1  sticky flag: a redirect target exceeded PC_W bits.
- TakenCount  out  32  number of accepted redirects (see Configuration).
- FlushCycles  out  32  number of squash cycles (see Configuration).

## Operation
- FSM states: RUN, SQUASH, HALTED. Reset state is RUN.
- Outputs are combinational from the current state and inputs. The next state, squash counter, HoldPC and flags are registered.
- **RUN**, evaluated in priority order Halt > PcSel > Stall:
  - Halt=1: PcWrite=0; FlushIF=FlushID=1; HoldPC<=CurPC; next state HALTED.
  - PcSel=1:
    - PcWrite=1; PcNext=BrPC[PC_W-1:0]; FlushIF=FlushID=1.
    - If BrPC[31:PC_W]!=0, set RangeErr.
    - If FLUSH_DEPTH>1, load cnt=FLUSH_DEPTH-1 and go to SQUASH; otherwise stay in RUN.
  - Stall=1: PcWrite=0; no flush.
  - Otherwise: PcWrite=1; PcNext=CurPC+4, truncated to PC_W (wraps modulo 2^PC_W).
- **SQUASH**:
  - PcSel and Halt are ignored, because they originate from squashed instructions.
  - FlushID=1; FlushIF=0; PcWrite=!Stall; PcNext=CurPC+4.
  - cnt decrements only on non-stalled cycles. When cnt reaches 1 and the cycle is not stalled, the next state is RUN.
- **HALTED**:
  - Halted=1; PcWrite=0; FlushIF=FlushID=1. PcSel, Halt and Stall are ignored.
  - Resume=1: PcWrite=1; PcNext=HoldPC+4; next state RUN. Halted deasserts in the following cycle.
- Resume outside HALTED has no effect.
- RangeErr clears only on reset.

## Timing
- Redirect has zero cycles of latency: PcNext and the flushes are valid in the same cycle as PcSel. The PC updates on the next rising edge.
- Total squash window after a redirect is exactly FLUSH_DEPTH non-stalled cycles, counting the PcSel cycle.
- Halt to Halted: 1 cycle. Resume to first fetch at HoldPC+4: 1 edge.
- While reset=1:
  - PcWrite=0, FlushIF=FlushID=1, Halted=0.
  - RangeErr, counters, HoldPC and cnt are all 0; state is RUN.
- Reset asserted mid-SQUASH or mid-HALTED returns to RUN immediately and asynchronously. No redirect survives the reset.
- PcSel and Stall in the same cycle: the redirect wins and the PC is written.

## Configuration
- BRANCH_CTRL_STATS_EN defined:
  - TakenCount increments on each accepted redirect (RUN with PcSel=1 and Halt=0).
  - FlushCycles increments on every cycle with FlushID=1 while not halted.
  - Both counters saturate at 32'hFFFF_FFFF and clear on reset.
- BRANCH_CTRL_STATS_EN undefined: the ports remain and are tied to 0; no counter logic is built.

## Structure
- Shared package branch_ctrl_pkg holds:
  - the state enum redirect_state_e {RUN, SQUASH, HALTED};
  - the constant PC_STEP=4;
  - the default FLUSH_DEPTH.
- One sub-module, sat_counter32: a saturating 32-bit counter with inc and reset inputs, instantiated twice under the macro.

## Test plan
- Reset → PcWrite=0, FlushIF=FlushID=1; after release with CurPC=0x010 and no requests → PcWrite=1, PcNext=0x014.
- RUN, PcSel=1, BrPC=0x40, FLUSH_DEPTH=2 → PcNext=0x040 with both flushes. Next cycle is SQUASH: FlushID=1, FlushIF=0, and a PcSel=1 in that cycle is ignored. Then back to RUN.
- Stall held for 3 cycles during SQUASH → cnt frozen, FlushID held, PcWrite=0; SQUASH exits one non-stalled cycle after Stall drops.
- Halt=1 with CurPC=0x1F0 → Halted rises next cycle, PC frozen; after 5 idle cycles, Resume → PcNext=0x1F4, back to RUN.
- PcSel=1, BrPC=0x0000_0204, PC_W=9 → PcNext=0x004, RangeErr=1 and sticky until reset. With CurPC=0x1FC and no request → PcNext=0x000 (wrap).
- BRANCH_CTRL_STATS_EN defined, 3 redirects with FLUSH_DEPTH=2 → TakenCount=3, FlushCycles=6. Macro undefined → both outputs read 0.
